// File: rtl/char_serializer.sv
// Parallel-to-serial character feeder: a small FIFO in front of an MSB-first shifter.
// Optional even-parity bit after the LSB when CHAR_SERIALIZER_PARITY_EN is defined.
module char_serializer #(
   parameter int unsigned CHAR_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned BIT_CYCLES = 1,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic [CHAR_WIDTH-1:0]         in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          serial_out,
   output logic                          serial_valid,
   output logic                          char_done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
`ifdef CHAR_SERIALIZER_PARITY_EN
   localparam int unsigned NBITS = CHAR_WIDTH + 1;
`else
   localparam int unsigned NBITS = CHAR_WIDTH;
`endif
   localparam int unsigned BIT_IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int unsigned CYC_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CHAR_WIDTH-1:0]   shift_q, shift_d;
   logic                    serial_out_q, serial_out_d;
   logic                    serial_valid_q, serial_valid_d;
   logic [BIT_IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic [CYC_W-1:0]        cyc_cnt_q, cyc_cnt_d;
`ifdef CHAR_SERIALIZER_PARITY_EN
   logic                    parity_q, parity_d;
`endif
   logic [CHAR_WIDTH-1:0]   mem_q [FIFO_DEPTH];

   logic                    full_c;
   logic                    empty_c;
   logic                    last_c;
   logic                    push_c;
   logic                    pop_c;
   logic                    hold_end_c;
   logic [CHAR_WIDTH-1:0]   head_c;

   // Pointer wrap bit distinguishes full from empty when the index bits match.
   assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign empty_c = (wr_ptr_q == rd_ptr_q);
   assign head_c  = mem_q[rd_ptr_q[PTR_W-1:0]];

   assign hold_end_c = (cyc_cnt_q == CYC_W'(BIT_CYCLES - 1));
   assign last_c     = (state_q == SHIFT) && hold_end_c &&
                       (bit_idx_q == BIT_IDX_W'(NBITS - 1));

   assign push_c = in_valid && !full_c && !flush;
   assign pop_c  = !flush && !empty_c && ((state_q == IDLE) || last_c);

   assign in_ready     = !full_c;
   assign fifo_count   = wr_ptr_q - rd_ptr_q;
   assign busy         = (state_q == SHIFT) || (fifo_count != '0);
   assign char_done    = last_c;
   assign serial_out   = serial_out_q;
   assign serial_valid = serial_valid_q;

   always_ff @(posedge clock) begin
      if (push_c) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data;
      end
   end

   // Next-state: flush dominates, then shift/advance, then a pop reloads the shifter.
   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      shift_d        = shift_q;
      serial_out_d   = serial_out_q;
      serial_valid_d = serial_valid_q;
      bit_idx_d      = bit_idx_q;
      cyc_cnt_d      = cyc_cnt_q;
`ifdef CHAR_SERIALIZER_PARITY_EN
      parity_d       = parity_q;
`endif

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + CNT_W'(1);
      end

      if (flush) begin
         state_d        = IDLE;
         rd_ptr_d       = wr_ptr_q;
         serial_out_d   = IDLE_LEVEL;
         serial_valid_d = 1'b0;
         bit_idx_d      = '0;
         cyc_cnt_d      = '0;
      end else begin
         case (state_q)
            IDLE: begin
               serial_out_d   = IDLE_LEVEL;
               serial_valid_d = 1'b0;
            end
            SHIFT: begin
               if (!hold_end_c) begin
                  cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
               end else if (bit_idx_q == BIT_IDX_W'(NBITS - 1)) begin
                  state_d        = IDLE;
                  serial_out_d   = IDLE_LEVEL;
                  serial_valid_d = 1'b0;
                  bit_idx_d      = '0;
                  cyc_cnt_d      = '0;
               end else begin
                  cyc_cnt_d = '0;
                  bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                  shift_d   = shift_q << 1;
`ifdef CHAR_SERIALIZER_PARITY_EN
                  serial_out_d = (bit_idx_q == BIT_IDX_W'(CHAR_WIDTH - 1)) ?
                                 parity_q : shift_q[CHAR_WIDTH-2];
`else
                  serial_out_d = shift_q[CHAR_WIDTH-2];
`endif
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // Load from the FIFO head: from IDLE, or seamlessly after the last bit.
         if (pop_c) begin
            rd_ptr_d       = rd_ptr_q + CNT_W'(1);
            state_d        = SHIFT;
            shift_d        = head_c;
            serial_out_d   = head_c[CHAR_WIDTH-1];
            serial_valid_d = 1'b1;
            bit_idx_d      = '0;
            cyc_cnt_d      = '0;
`ifdef CHAR_SERIALIZER_PARITY_EN
            parity_d       = ^head_c;
`endif
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         shift_q        <= '0;
         serial_out_q   <= IDLE_LEVEL;
         serial_valid_q <= 1'b0;
         bit_idx_q      <= '0;
         cyc_cnt_q      <= '0;
`ifdef CHAR_SERIALIZER_PARITY_EN
         parity_q       <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         shift_q        <= shift_d;
         serial_out_q   <= serial_out_d;
         serial_valid_q <= serial_valid_d;
         bit_idx_q      <= bit_idx_d;
         cyc_cnt_q      <= cyc_cnt_d;
`ifdef CHAR_SERIALIZER_PARITY_EN
         parity_q       <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_char_serializer.sv
// Directed self-checking bench for char_serializer: one instance at BIT_CYCLES=1, one at 3.
module tb_char_serializer;

`ifdef CHAR_SERIALIZER_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;

   logic       flush1 = 1'b0, valid1 = 1'b0;
   logic [7:0] data1 = 8'h00;
   logic       ready1, so1, sv1, cd1, busy1;
   logic [2:0] cnt1;

   logic       flush3 = 1'b0, valid3 = 1'b0;
   logic [7:0] data3 = 8'h00;
   logic       ready3, so3, sv3, cd3, busy3;
   logic [2:0] cnt3;

   int compared = 0;
   int mismatched = 0;
   int done_cnt = 0;
   int d0;
   bit rec = 1'b0;
   logic bits[$];
   logic [7:0] chars [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   always #5 clock = ~clock;

   char_serializer #(.CHAR_WIDTH(8), .FIFO_DEPTH(4), .BIT_CYCLES(1), .IDLE_LEVEL(1'b0)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .flush(flush1), .in_data(data1), .in_valid(valid1),
      .in_ready(ready1), .serial_out(so1), .serial_valid(sv1), .char_done(cd1),
      .busy(busy1), .fifo_count(cnt1));

   char_serializer #(.CHAR_WIDTH(8), .FIFO_DEPTH(4), .BIT_CYCLES(3), .IDLE_LEVEL(1'b0)) u_dut3 (
      .clock(clock), .reset_n(reset_n), .flush(flush3), .in_data(data3), .in_valid(valid3),
      .in_ready(ready3), .serial_out(so3), .serial_valid(sv3), .char_done(cd3),
      .busy(busy3), .fifo_count(cnt3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] c, input int i);
      if (i < 8) return c[7-i];
      return ^c;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
      if (rec && sv1) bits.push_back(so1);
      if (cd1) done_cnt++;
   endtask

   task automatic chk_idle1(input string tag);
      chk({tag, "_so"}, 32'(so1), 32'd0);
      chk({tag, "_sv"}, 32'(sv1), 32'd0);
      chk({tag, "_cd"}, 32'(cd1), 32'd0);
      chk({tag, "_busy"}, 32'(busy1), 32'd0);
      chk({tag, "_cnt"}, 32'(cnt1), 32'd0);
      chk({tag, "_rdy"}, 32'(ready1), 32'd1);
   endtask

   initial begin
      // Reset held for 3 cycles, then released with no input
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle1("rst_hold");
      end
      chk("rst_sv3", 32'(sv3), 32'd0);
      chk("rst_rdy3", 32'(ready3), 32'd1);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle1("rst_idle");
      end

      // Single character 0xB0
      valid1 = 1'b1; data1 = 8'hB0;
      step();
      valid1 = 1'b0; data1 = 8'hFF;
      chk("single_cnt", 32'(cnt1), 32'd1);
      chk("single_sv_pre", 32'(sv1), 32'd0);
      chk("single_busy", 32'(busy1), 32'd1);
      for (int i = 0; i < NB; i++) begin
         step();
         chk("single_so", 32'(so1), 32'(exp_bit(8'hB0, i)));
         chk("single_sv", 32'(sv1), 32'd1);
         chk("single_cd", 32'(cd1), 32'(i == NB-1));
      end
      step();
      chk_idle1("single_after");

      // Back-to-back 0x55 then 0xAA
      valid1 = 1'b1; data1 = 8'h55;
      step();
      data1 = 8'hAA;
      step();
      valid1 = 1'b0;
      for (int i = 0; i < 2*NB; i++) begin
         chk("b2b_so", 32'(so1), 32'(exp_bit((i < NB) ? 8'h55 : 8'hAA, i % NB)));
         chk("b2b_sv", 32'(sv1), 32'd1);
         chk("b2b_cd", 32'(cd1), 32'((i % NB) == NB-1));
         step();
      end
      chk_idle1("b2b_after");

      // Full FIFO with in_valid held high
      bits.delete();
      rec = 1'b1;
      d0 = done_cnt;
      begin
         int idx;
         bit will_push;
         idx = 0;
         valid1 = 1'b1; data1 = chars[0];
         for (int cyc = 0; cyc < 300 && idx < 6; cyc++) begin
            will_push = ready1;
            step();
            if (will_push) idx++;
            if (cyc == 4) begin
               chk("full_cnt", 32'(cnt1), 32'd4);
               chk("full_rdy", 32'(ready1), 32'd0);
            end
            if (cyc == 5) chk("full_blocked_cnt", 32'(cnt1), 32'd4);
            if (idx < 6) data1 = chars[idx];
            else valid1 = 1'b0;
         end
         chk("full_all_accepted", 32'(idx), 32'd6);
         valid1 = 1'b0;
      end
      for (int cyc = 0; cyc < 300 && busy1; cyc++) step();
      step();
      rec = 1'b0;
      chk("full_drained_busy", 32'(busy1), 32'd0);
      chk("full_nbits", 32'(bits.size()), 32'(6*NB));
      chk("full_done", 32'(done_cnt - d0), 32'd6);
      if (bits.size() == 6*NB) begin
         for (int k = 0; k < 6; k++) begin
            logic [7:0] got;
            for (int b = 0; b < 8; b++) got[7-b] = bits[k*NB + b];
            chk("full_order", 32'(got), 32'(chars[k]));
            if (NB == 9) chk("full_parity", 32'(bits[k*NB + 8]), 32'(^chars[k]));
         end
      end

      // Bit stretch on the BIT_CYCLES=3 instance, 0x80
      valid3 = 1'b1; data3 = 8'h80;
      step();
      valid3 = 1'b0;
      for (int i = 0; i < 3*NB; i++) begin
         step();
         chk("stretch_so", 32'(so3), 32'(exp_bit(8'h80, i / 3)));
         chk("stretch_sv", 32'(sv3), 32'd1);
         chk("stretch_cd", 32'(cd3), 32'(i == 3*NB-1));
      end
      step();
      chk("stretch_after_sv", 32'(sv3), 32'd0);
      chk("stretch_after_busy", 32'(busy3), 32'd0);

      // Flush during bit 4 of the first of three characters
      valid1 = 1'b1; data1 = 8'hC3;
      step();
      data1 = 8'h3C;
      step();
      data1 = 8'h5A;
      step();
      valid1 = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("flush_pre_so", 32'(so1), 32'(exp_bit(8'hC3, 4)));
      chk("flush_pre_cnt", 32'(cnt1), 32'd2);
      d0 = done_cnt;
      flush1 = 1'b1; valid1 = 1'b1; data1 = 8'h77;
      step();
      flush1 = 1'b0; valid1 = 1'b0;
      chk_idle1("flush_post");
      for (int i = 0; i < 12; i++) step();
      chk_idle1("flush_quiet");
      chk("flush_no_done", 32'(done_cnt - d0), 32'd0);

      // Reset pulsed between edges mid-character
      valid1 = 1'b1; data1 = 8'h96;
      step();
      data1 = 8'h69;
      step();
      valid1 = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("rstmid_pre_sv", 32'(sv1), 32'd1);
      d0 = done_cnt;
      #2 reset_n = 1'b0;
      #1 chk_idle1("rstmid_async");
      #1 reset_n = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk_idle1("rstmid_quiet");
      chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
